// File: rtl/bitdump_pkg.sv
// Shared types and constants for the bitdump capture block and its SPI decoder.
package bitdump_pkg;

  localparam int BYTE_W       = 8;
  localparam int MAX_CHANNELS = 8;

  // SPI command addresses decoded alongside this block
  localparam logic [7:0] ADDR_PARAM = 8'h55;
  localparam logic [7:0] ADDR_ECHO  = 8'h56;
  localparam logic [7:0] ADDR_DUMP  = 8'h57;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

endpackage

// File: rtl/bitdump_packer.sv
// Compacts the masked channel bits of each sample tick and packs them
// LSB-first into bytes. At most one byte completes per tick.
module bitdump_packer
  import bitdump_pkg::*;
#(
  parameter int CHANNELS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                tick,
  input  logic                flush,
  input  logic                full,
  input  logic [CHANNELS-1:0] sig,
  input  logic [CHANNELS-1:0] chan_mask,
  output logic [BYTE_W-1:0]   byte_out,
  output logic                byte_stb
);

  // Up to 7 leftover bits plus one full sample of every channel
  localparam int ACC_W = BYTE_W - 1 + CHANNELS;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] packed_bits;
  logic [ACC_W-1:0] merged;
  logic [3:0]       cnt;
  logic [3:0]       k;
  logic [3:0]       total;

  // Squeeze out unmasked channels (ascending index) and append above held bits
  always_comb begin
    packed_bits = '0;
    k           = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_mask[i]) begin
        packed_bits = packed_bits | (ACC_W'(sig[i]) << k);
        k           = k + 4'd1;
      end
    end
    merged = acc | (packed_bits << cnt);
    total  = cnt + k;
  end

  // Accumulator: emit a byte once 8 bits are held; flush pads the partial byte with zeros
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc      <= '0;
      cnt      <= '0;
      byte_out <= '0;
      byte_stb <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      if (flush) begin
        if (cnt != 4'd0 && !full) begin
          byte_out <= acc[BYTE_W-1:0];
          byte_stb <= 1'b1;
        end
        acc <= '0;
        cnt <= '0;
      end else if (tick) begin
        if (total >= 4'd8) begin
          byte_out <= merged[BYTE_W-1:0];
          byte_stb <= 1'b1;
          acc      <= merged >> BYTE_W;
          cnt      <= total - 4'd8;
        end else begin
          acc <= merged;
          cnt <= total;
        end
      end
    end
  end

endmodule

// File: rtl/bitdump_capture.sv
// N-channel bit dumper: decimated sampling, byte packing and a DEPTH-byte FIFO
// drained by the SPI command logic. Optional trigger arming with BITDUMP_TRIG_EN
// (adds the ARMED state and the trig_sel port).
//
// Read handshake: rd_valid=1 means rd_byte holds the FIFO head. A rd_next pulse
// while rd_valid=1 pops it; the next byte (or rd_valid=0) shows one cycle later.
// rd_next while rd_valid=0 is ignored.
module bitdump_capture
  import bitdump_pkg::*;
#(
  parameter int  CHANNELS = 2,
  parameter int  DEPTH    = 256,
  parameter int  DECIM_W  = 8,
  localparam int TRIG_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sig,
  input  logic [CHANNELS-1:0] chan_mask,
  input  logic [DECIM_W-1:0]  decim,
  input  logic                arm,
  input  logic                stop,
  input  logic                pause,
`ifdef BITDUMP_TRIG_EN
  input  logic [TRIG_W-1:0]   trig_sel,
`endif
  input  logic                rd_next,
  output logic [BYTE_W-1:0]   rd_byte,
  output logic                rd_valid,
  output logic                full,
  output logic                overflow,
  output logic                busy
);

  localparam int AW = $clog2(DEPTH);

`ifdef BITDUMP_TRIG_EN
  localparam state_t ARM_TARGET = ARMED;
`else
  localparam state_t ARM_TARGET = CAPTURE;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [DECIM_W-1:0] dcnt;
  logic               phase_hit;
  logic               tick;
  logic [BYTE_W-1:0]  byte_out;
  logic               byte_stb;
  logic [BYTE_W-1:0]  mem [DEPTH];
  logic [AW:0]        wptr;
  logic [AW:0]        rptr;
  logic [AW:0]        rptr_nxt;
  logic               pop;

`ifdef BITDUMP_TRIG_EN
  logic trig_prev;
  logic trig_rise;

  assign trig_rise = sig[trig_sel] & ~trig_prev;

  // Previous trigger-channel value for edge detection; arm forgets history
  always_ff @(posedge clk) begin
    if (rst || arm) trig_prev <= 1'b0;
    else            trig_prev <= sig[trig_sel];
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: arm restarts from anywhere and beats stop
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arm) state_nxt = ARM_TARGET;
`ifdef BITDUMP_TRIG_EN
      ARMED: begin
        if (arm)            state_nxt = ARMED;
        else if (stop)      state_nxt = IDLE;
        else if (trig_rise) state_nxt = CAPTURE;
      end
`endif
      CAPTURE: begin
        if (arm)       state_nxt = ARM_TARGET;
        else if (stop) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = arm ? ARM_TARGET : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign phase_hit = (dcnt == decim);
  // pause only hides the tick; the phase counter keeps running underneath
  assign tick      = (state == CAPTURE) && phase_hit && !pause && !arm;
  assign busy      = (state != IDLE);

  // Decimation counter; wraps at DECIM_W overflow if decim drops below it
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      dcnt <= '0;
`ifdef BITDUMP_TRIG_EN
    end else if (state == ARMED && !stop && trig_rise) begin
      dcnt <= decim;
`endif
    end else if (state == CAPTURE) begin
      dcnt <= phase_hit ? '0 : dcnt + 1'b1;
    end
  end

  bitdump_packer #(.CHANNELS(CHANNELS)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (arm),
    .tick      (tick),
    .flush     (state == FLUSH),
    .full      (full),
    .sig       (sig),
    .chan_mask (chan_mask),
    .byte_out  (byte_out),
    .byte_stb  (byte_stb)
  );

  // Full is judged on the current pointers, before any same-cycle pop
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop      = rd_next && rd_valid;
  assign rptr_nxt = pop ? rptr + 1'b1 : rptr;

  // FIFO storage write (no reset so it can map to RAM)
  always_ff @(posedge clk) begin
    if (!rst && !arm && byte_stb && !full) mem[wptr[AW-1:0]] <= byte_out;
  end

  // Pointers, registered head byte and sticky overflow
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_byte  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (byte_stb) begin
        if (full) overflow <= 1'b1;
        else      wptr     <= wptr + 1'b1;
      end
      rptr     <= rptr_nxt;
      rd_byte  <= mem[rptr_nxt[AW-1:0]];
      rd_valid <= (rptr_nxt != wptr);
    end
  end

endmodule
